// File: rtl/score_keeper.sv
// score_keeper: whack-a-mole game controller with tick timers and score.
// Build macro SCORE_PENALTY_EN: a wrong press while a mole shows costs a point.
module score_keeper #(
  parameter int TICK_DIV   = 1000000,
  parameter int GAME_TICKS = 60,
  parameter int MOLE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] btn,
  input  logic [2:0] mole_pos,
  input  logic       mole_vld,
  output logic       mole_req,
  output logic [7:0] mole_led,
  output logic [5:0] score,
  output logic       playing,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    SHOW  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(TICK_DIV - 1);
  localparam logic [7:0] GT = 8'(GAME_TICKS);
  localparam logic [3:0] MT = 4'(MOLE_TICKS);

  state_t state, state_d;

  logic [7:0]    btn_q;
  logic          start_q;
  logic [7:0]    press;
  logic          start_e;

  logic [DW-1:0] div, div_d;
  logic [7:0]    gtm, gtm_d;
  logic [3:0]    mtm, mtm_d;
  logic [2:0]    pos, pos_d;
  logic [5:0]    score_d;
  logic          req_d;
  logic [7:0]    led_d;

  logic          act;
  logic          tick;
  logic          gend;
  logic          mend;
  logic          hit;
`ifdef SCORE_PENALTY_EN
  logic          wrong;
`endif

  assign press   = btn & ~btn_q;
  assign start_e = start & ~start_q;

  // Edge-detect history for buttons and start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q   <= '0;
      start_q <= 1'b0;
    end else begin
      btn_q   <= btn;
      start_q <= start;
    end
  end

  // Next-state, timers, divider and score update.
  always_comb begin
    state_d = state;
    div_d   = div;
    gtm_d   = gtm;
    mtm_d   = mtm;
    pos_d   = pos;
    score_d = score;
    req_d   = 1'b0;
    act     = (state == SPAWN) || (state == SHOW);
    tick    = 1'b0;
    gend    = 1'b0;
    mend    = 1'b0;
    hit     = 1'b0;
`ifdef SCORE_PENALTY_EN
    wrong   = 1'b0;
`endif
    if (start_e) begin
      state_d = SPAWN;
      score_d = '0;
      gtm_d   = GT;
      div_d   = '0;
      req_d   = 1'b1;
    end else if (act) begin
      tick  = (div == DMAX);
      div_d = tick ? '0 : div + 1'b1;
      gend  = tick && (gtm == 8'd1);
      if (tick)
        gtm_d = gtm - 1'b1;
      if (state == SHOW) begin
        hit  = press[pos];
        mend = tick && (mtm == 4'd1);
        if (tick)
          mtm_d = mtm - 1'b1;
`ifdef SCORE_PENALTY_EN
        wrong = |(press & ~(8'd1 << pos));
`endif
      end
      if (hit) begin
        if (score != 6'd63)
          score_d = score + 1'b1;
      end
`ifdef SCORE_PENALTY_EN
      else if (wrong) begin
        if (score != 6'd0)
          score_d = score - 1'b1;
      end
`endif
      if (gend) begin
        state_d = OVER;
      end else if (state == SPAWN) begin
        if (mole_vld) begin
          pos_d   = mole_pos;
          mtm_d   = MT;
          state_d = SHOW;
        end
      end else if (hit || mend) begin
        state_d = SPAWN;
        req_d   = 1'b1;
      end
    end
    led_d = (state_d == SHOW) ? (8'd1 << pos_d) : 8'd0;
  end

  // State, timers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div       <= '0;
      gtm       <= '0;
      mtm       <= '0;
      pos       <= '0;
      score     <= '0;
      mole_req  <= 1'b0;
      mole_led  <= '0;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_d;
      div       <= div_d;
      gtm       <= gtm_d;
      mtm       <= mtm_d;
      pos       <= pos_d;
      score     <= score_d;
      mole_req  <= req_d;
      mole_led  <= led_d;
      playing   <= (state_d == SPAWN) || (state_d == SHOW);
      game_over <= (state_d == OVER);
    end
  end

endmodule
